// File: rtl/wbuf_pkg.sv
// Shared parameters and types for the write-data buffer controller.
package wbuf_pkg;
  localparam int DATA_W       = 518;
  localparam int DEPTH        = 64;
  localparam int AW           = $clog2(DEPTH);
  localparam int STARVE_LIMIT = 4;

  typedef logic [AW-1:0] slot_id_t;
endpackage

// File: rtl/wdata_buf_ctrl_if.sv
// Host fill and scheduler drain handshakes of the write-data buffer.
interface wdata_buf_ctrl_if;
  import wbuf_pkg::*;

  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  slot_id_t          wr_slot;
  logic              rd_valid;
  logic              rd_ready;
  slot_id_t          rd_slot;
  logic              rd_data_valid;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output wr_valid, wr_data, rd_valid, rd_slot,
    input  wr_ready, wr_slot, rd_ready, rd_data_valid, rd_data
  );

  modport slave (
    input  wr_valid, wr_data, rd_valid, rd_slot,
    output wr_ready, wr_slot, rd_ready, rd_data_valid, rd_data
  );
endinterface

// File: rtl/wbuf_free_enc.sv
// Lowest-index free slot finder; free_vec bit i is 1 when slot i is free.
module wbuf_free_enc
  import wbuf_pkg::*;
(
  input  logic [DEPTH-1:0] free_vec,
  output logic             found,
  output slot_id_t         index
);
  always_comb begin
    found = 1'b0;
    index = '0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (free_vec[i]) begin
        found = 1'b1;
        index = slot_id_t'(i);
      end
    end
  end
endmodule

// File: rtl/wdata_buf_ctrl.sv
// Write-data SRAM slot allocator with drain-priority arbitration of the single
// SRAM port; fill wins after STARVE_LIMIT consecutive contended drains.
module wdata_buf_ctrl
  import wbuf_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  wdata_buf_ctrl_if.slave   bus,
  output logic [AW:0]       free_cnt,
  output logic              err_rd_free,
  output logic              sram_cs_n,
  output logic              sram_wr_n,
  output slot_id_t          sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout
);
  localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0] CNT_DEPTH = (AW+1)'(DEPTH);

  logic [DEPTH-1:0]  bitmap_reg;
  logic [AW:0]       free_cnt_reg;
  logic [2:0]        starve_cnt_reg;
  logic              rd_data_valid_reg;
  logic              err_reg;
  slot_id_t          sram_addr_reg;
  logic [DATA_W-1:0] sram_din_reg;

  logic     found;
  slot_id_t cand;
  logic     contended;
  logic     starve_hit;
  logic     fill_grant;
  logic     drain_grant;
  logic     rd_alloc;

  wbuf_free_enc u_free_enc (
    .free_vec (~bitmap_reg),
    .found    (found),
    .index    (cand)
  );

  assign contended  = bus.wr_valid & found & bus.rd_valid;
  assign starve_hit = (starve_cnt_reg == 3'(STARVE_LIMIT));
  // Grants are masked during reset so the reset cycle never touches the SRAM.
  assign fill_grant  = rst_n & bus.wr_valid & found & (~bus.rd_valid | starve_hit);
  assign drain_grant = rst_n & bus.rd_valid & ~(contended & starve_hit);
  assign rd_alloc    = bitmap_reg[bus.rd_slot];

  assign bus.wr_ready      = fill_grant;
  assign bus.wr_slot       = cand;
  assign bus.rd_ready      = drain_grant;
  assign bus.rd_data_valid = rd_data_valid_reg;
  assign bus.rd_data       = sram_dout;

  assign free_cnt    = free_cnt_reg;
  assign err_rd_free = err_reg;

  always_comb begin
    sram_cs_n = ~(fill_grant | drain_grant);
    sram_wr_n = ~fill_grant;
    sram_addr = sram_addr_reg;
    sram_din  = sram_din_reg;
    if (fill_grant) begin
      sram_addr = cand;
      sram_din  = bus.wr_data;
    end else if (drain_grant) begin
      sram_addr = bus.rd_slot;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bitmap_reg        <= '0;
      free_cnt_reg      <= CNT_DEPTH;
      starve_cnt_reg    <= '0;
      rd_data_valid_reg <= 1'b0;
      err_reg           <= 1'b0;
      sram_addr_reg     <= '0;
      sram_din_reg      <= '0;
    end else begin
      rd_data_valid_reg <= drain_grant;
      sram_addr_reg     <= sram_addr;
      sram_din_reg      <= sram_din;

      if (fill_grant) begin
        bitmap_reg[cand] <= 1'b1;
        free_cnt_reg     <= free_cnt_reg - CNT_ONE;
      end else if (drain_grant) begin
        if (rd_alloc) begin
          bitmap_reg[bus.rd_slot] <= 1'b0;
          free_cnt_reg            <= free_cnt_reg + CNT_ONE;
        end else begin
          err_reg <= 1'b1;
        end
      end

      if (fill_grant || !contended) begin
        starve_cnt_reg <= '0;
      end else if (drain_grant) begin
        starve_cnt_reg <= starve_cnt_reg + 3'd1;
      end
    end
  end
endmodule
